// File: rtl/norm_round_cg2.sv
// rtl/norm_round_cg2.sv - 3-stage normalize/round/clamp of the MAC accumulator sum
// Define NORM_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module norm_round_cg2 #(
  parameter int ACC_W  = 18,
  parameter int PT     = 13,
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  acc,
  input  logic [EXP_W-1:0]  max_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [50:0]       number
);

  localparam int PW    = $clog2(ACC_W);
  localparam int EW2   = EXP_W + 2;
  localparam int TOP_W = FRAC_W + 1;
  localparam int LOW_W = ACC_W - 1 - FRAC_W;

`ifdef NORM_RNE_EN
  localparam int RND_REGS = 2;
  localparam int RND_COST = LOW_W * 2 + 3 + TOP_W * 5 + EW2 * 5;
`else
  localparam int RND_REGS = 0;
  localparam int RND_COST = 0;
`endif

  // Nominal primitive costs: 6 per flop bit, 5 per adder bit, 3 per mux bit, 2 per inverter/OR/compare bit.
  localparam int REG_BITS = (2 + ACC_W + PW + EXP_W) + (3 + FRAC_W + EW2) + (2 + EXP_W + FRAC_W) + RND_REGS;
  localparam int NUM_TOTAL = REG_BITS * 6 + ACC_W * 2 + ACC_W * 5 + ACC_W * 3 + ACC_W * 2
                           + PW * 5 + ACC_W * PW * 3 + 2 * EW2 * 5 + 2 * EW2 * 2
                           + (1 + EXP_W + FRAC_W) * 2 * 3 + RND_COST;

  assign number = 51'(NUM_TOTAL);

  logic en;
  assign in_ready = !out_valid || out_ready;
  assign en       = in_ready;

  logic              v1, sign1;
  logic [ACC_W-1:0]  mag1;
  logic [PW-1:0]     p1;
  logic [EXP_W-1:0]  max_exp1;

  logic              v2, sign2, zero2;
  logic [FRAC_W-1:0] frac2;
  logic [EW2-1:0]    e2;

  logic [ACC_W-1:0]  mag_n;
  logic [PW-1:0]     p_n;
  always_comb begin
    mag_n = acc[ACC_W-1] ? -acc : acc;
    p_n   = '0;
    for (int i = 0; i < ACC_W; i++)
      if (mag_n[i]) p_n = PW'(i);
  end

  // The leading one lands at the top bit, so that bit doubles as the nonzero flag.
  logic [PW-1:0]    sh;
  logic [TOP_W-1:0] norm_top;
  logic [EW2-1:0]   e_n;
  always_comb begin
    sh       = PW'(ACC_W - 1) - p1;
    norm_top = TOP_W'((mag1 << sh) >> LOW_W);
    e_n      = EW2'(max_exp1) + EW2'(p1) - EW2'(PT);
  end

  logic [FRAC_W-1:0] frac_r;
  logic [EW2-1:0]    e_r;
  logic              neg, over;

`ifdef NORM_RNE_EN
  logic             guard2, sticky2;
  logic [LOW_W-1:0] norm_low;
  logic             round_up, carry;
  always_comb begin
    norm_low          = LOW_W'(mag1 << sh);
    round_up          = guard2 & (sticky2 | frac2[0]);
    {carry, frac_r}   = {1'b0, frac2} + TOP_W'(round_up);
    e_r               = e2 + EW2'(carry);
  end
`else
  always_comb begin
    frac_r = frac2;
    e_r    = e2;
  end
`endif

  assign neg  = e_r[EW2-1];
  assign over = !neg && (|e_r[EW2-2:EXP_W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      sign1     <= 1'b0;
      mag1      <= '0;
      p1        <= '0;
      max_exp1  <= '0;
      v2        <= 1'b0;
      sign2     <= 1'b0;
      zero2     <= 1'b0;
      frac2     <= '0;
      e2        <= '0;
`ifdef NORM_RNE_EN
      guard2    <= 1'b0;
      sticky2   <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
    end else if (en) begin
      v1        <= in_valid;
      sign1     <= acc[ACC_W-1];
      mag1      <= mag_n;
      p1        <= p_n;
      max_exp1  <= max_exp;

      v2        <= v1;
      sign2     <= sign1;
      zero2     <= ~norm_top[FRAC_W];
      frac2     <= norm_top[FRAC_W-1:0];
      e2        <= e_n;
`ifdef NORM_RNE_EN
      guard2    <= norm_low[LOW_W-1];
      sticky2   <= |norm_low[LOW_W-2:0];
`endif

      out_valid <= v2;
      if (zero2 || neg) begin
        out_sign <= 1'b0;
        out_exp  <= '0;
        out_frac <= '0;
      end else if (over) begin
        out_sign <= sign2;
        out_exp  <= '1;
        out_frac <= '1;
      end else begin
        out_sign <= sign2;
        out_exp  <= e_r[EXP_W-1:0];
        out_frac <= frac_r;
      end
    end
  end

endmodule

// File: tb/tb_norm_round_cg2.sv
// tb/tb_norm_round_cg2.sv - self-checking bench for norm_round_cg2 (honours NORM_RNE_EN)
module tb_norm_round_cg2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] acc = '0;
  logic [5:0]  max_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [5:0]  out_exp;
  logic [1:0]  out_frac;
  logic [50:0] number;

  norm_round_cg2 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc(acc), .max_exp(max_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac), .number(number)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_out = 0;
  logic       check_lat = 1'b0;
  logic       stalled_prev = 1'b0;
  logic [9:0] held = '0;
  logic [8:0] exp_q[$];
  int         lat_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact rational value mag * 2^(max_exp - PT), normalised to 1.ff * 2^e.
  function automatic logic [8:0] model(input logic [17:0] a, input logic [5:0] me);
    longint v, mag, q, r, unit;
    int p, e, frac;
    v   = a[17] ? longint'(a) - 262144 : longint'(a);
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 9'd0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e    = int'(me) + p - 13;
    unit = longint'(1) << p;
    q    = (mag << 2) >> p;
    r    = (mag << 2) - (q << p);
    frac = int'(q) - 4;
`ifdef NORM_RNE_EN
    if ((2 * r > unit) || ((2 * r == unit) && (frac % 2 == 1))) frac++;
    if (frac == 4) begin
      frac = 0;
      e++;
    end
`endif
    if (e < 0) return 9'd0;
    if (e > 63) return {a[17], 6'h3F, 2'b11};
    return {a[17], 6'(e), 2'(frac)};
  endfunction

  task automatic step(input logic iv, input logic [17:0] a, input logic [5:0] me, input logic ordy,
                      input logic use_tab, input logic [8:0] tab, output logic accepted);
    logic [8:0] expv;
    int l;
    @(negedge clk);
    in_valid  = iv;
    acc       = a;
    max_exp   = me;
    out_ready = ordy;
    #1;
    if (stalled_prev) check("hold", {22'd0, out_valid, out_sign, out_exp, out_frac}, {22'd0, held});
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() > 0) expv = exp_q.pop_front();
      else expv = 'x;
      check("result", {23'd0, out_sign, out_exp, out_frac}, {23'd0, expv});
      if (lat_q.size() > 0) begin
        l = lat_q.pop_front();
        if (check_lat) check("latency", 32'(cyc - l), 32'd3);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(use_tab ? tab : model(a, me));
      lat_q.push_back(cyc);
    end
    stalled_prev = out_valid && !out_ready;
    held = {out_valid, out_sign, out_exp, out_frac};
    cyc++;
  endtask

  localparam int ND = 16;
  logic [17:0] t_acc [ND] = '{18'h02000, 18'h03800, 18'h04000, 18'h3E000, 18'h20000, 18'h02500,
                              18'h02400, 18'h03C00, 18'h00001, 18'h00000, 18'h10000, 18'h03000,
                              18'h01800, 18'h03C00, 18'h3DB00, 18'h02000};
  logic [5:0]  t_exp [ND] = '{6'd20, 6'd20, 6'd20, 6'd20, 6'd20, 6'd20, 6'd20, 6'd20,
                              6'd5, 6'd20, 6'd62, 6'd0, 6'd0, 6'd63, 6'd20, 6'd0};
`ifdef NORM_RNE_EN
  logic [8:0]  t_res [ND] = '{{1'b0, 6'd20, 2'd0}, {1'b0, 6'd20, 2'd3}, {1'b0, 6'd21, 2'd0},
                              {1'b1, 6'd20, 2'd0}, {1'b1, 6'd24, 2'd0}, {1'b0, 6'd20, 2'd1},
                              {1'b0, 6'd20, 2'd0}, {1'b0, 6'd21, 2'd0}, 9'd0, 9'd0,
                              {1'b0, 6'd63, 2'd3}, {1'b0, 6'd0, 2'd2}, 9'd0,
                              {1'b0, 6'd63, 2'd3}, {1'b1, 6'd20, 2'd1}, {1'b0, 6'd0, 2'd0}};
`else
  logic [8:0]  t_res [ND] = '{{1'b0, 6'd20, 2'd0}, {1'b0, 6'd20, 2'd3}, {1'b0, 6'd21, 2'd0},
                              {1'b1, 6'd20, 2'd0}, {1'b1, 6'd24, 2'd0}, {1'b0, 6'd20, 2'd0},
                              {1'b0, 6'd20, 2'd0}, {1'b0, 6'd20, 2'd3}, 9'd0, 9'd0,
                              {1'b0, 6'd63, 2'd3}, {1'b0, 6'd0, 2'd2}, 9'd0,
                              {1'b0, 6'd63, 2'd3}, {1'b1, 6'd20, 2'd0}, {1'b0, 6'd0, 2'd0}};
`endif

  function automatic logic [17:0] rand_acc();
    logic [17:0] a;
    a = 18'($urandom) >> $urandom_range(0, 17);
    if ($urandom_range(0, 1) == 1) a = -a;
    if ($urandom_range(0, 15) == 0) a = '0;
    return a;
  endfunction

  initial begin
    logic ok;
    logic ordy;
    int sent, out0;
    logic [17:0] bp_acc [5];
    logic [5:0]  bp_exp [5];

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", {21'd0, in_ready, out_valid, out_sign, out_exp, out_frac}, {21'd0, 1'b1, 10'd0});
    check("number_nonzero", {31'd0, number != 51'd0}, 32'd1);

    // Directed values, back-to-back, with fixed 3-cycle latency.
    check_lat = 1'b1;
    for (int i = 0; i < ND; i++) step(1'b1, t_acc[i], t_exp[i], 1'b1, 1'b1, t_res[i], ok);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0, ok);
    check("directed_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: 5 items, consumer stalls 4 cycles from the first out_valid.
    check_lat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_acc[i] = rand_acc();
      bp_exp[i] = 6'($urandom_range(0, 63));
    end
    sent = 0;
    out0 = n_out;
    for (int k = 0; k < 40 && (sent < 5 || exp_q.size() > 0); k++) begin
      ordy = !(k >= 3 && k <= 6);
      step(sent < 5, (sent < 5) ? bp_acc[sent] : 18'd0, (sent < 5) ? bp_exp[sent] : 6'd0,
           ordy, 1'b0, '0, ok);
      if (k == 3) check("bp_first_valid", {31'd0, out_valid}, 32'd1);
      if (!ordy) check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (ok) sent++;
    end
    check("bp_sent", 32'(sent), 32'd5);
    check("bp_delivered", 32'(n_out - out0), 32'd5);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) step(1'b1, rand_acc(), 6'($urandom_range(0, 63)), 1'b1, 1'b0, '0, ok);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, '0, ok);
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    check_lat = 1'b1;
    step(1'b1, 18'h03800, 6'd20, 1'b1, 1'b1, {1'b0, 6'd20, 2'd3}, ok);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0, ok);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic with random backpressure against the reference model.
    check_lat = 1'b0;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, rand_acc(), 6'($urandom_range(0, 63)),
           $urandom_range(0, 9) < 7, 1'b0, '0, ok);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0, ok);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
